// File: rtl/sprite_pkg.sv
// Shared types and sprite artwork for the animated sprite bitmaps.
// Holds the pixel type, the transparent colour key, the sequencer state enum
// and the constant that defines the sprite frames held in sprite_frame_rom.
package sprite_pkg;

  typedef logic [7:0] rgb_t;

  // Pixels equal to this value are not drawn by the objects mux.
  localparam rgb_t TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    ONESHOT,
    DONE
  } anim_state_t;

  // Artwork for this sprite: bits [7:6] carry the frame number, [5:3] the row
  // and [2:0] the column (each modulo its field size). Frame 3 therefore has
  // transparent pixels wherever row%8 == 7 and col%8 == 7.
  function automatic rgb_t sprite_pixel(input int frame, input int row, input int col);
    return rgb_t'((frame % 4) * 64 + (row % 8) * 8 + (col % 8));
  endfunction

endpackage

// File: rtl/sprite_frame_rom.sv
// Sprite frame ROM: registered read of one pixel, indexed [frame][row][col].
// Latency 1 clk; no backpressure, one read per clk.
// Ports: clk, reset (sync, active-high), pix_vld/frame/row/col read request,
//        rgb registered pixel (transparent when pix_vld=0 or in reset).
module sprite_frame_rom
  import sprite_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 26,
  parameter int OBJECT_HEIGHT_Y = 26,
  parameter int FRAME_COUNT     = 4,
  localparam int FW = (FRAME_COUNT     > 1) ? $clog2(FRAME_COUNT)     : 1,
  localparam int RW = (OBJECT_HEIGHT_Y > 1) ? $clog2(OBJECT_HEIGHT_Y) : 1,
  localparam int CW = (OBJECT_WIDTH_X  > 1) ? $clog2(OBJECT_WIDTH_X)  : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_vld,
  input  logic [FW-1:0] frame,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output rgb_t          rgb
);

  rgb_t rom_mem [FRAME_COUNT][OBJECT_HEIGHT_Y][OBJECT_WIDTH_X];

  for (genvar f = 0; f < FRAME_COUNT; f++) begin : g_frame
    for (genvar r = 0; r < OBJECT_HEIGHT_Y; r++) begin : g_row
      for (genvar c = 0; c < OBJECT_WIDTH_X; c++) begin : g_col
        assign rom_mem[f][r][c] = sprite_pixel(f, r, c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= TRANSPARENT_ENCODING;
    end else begin
      rgb <= pix_vld ? rom_mem[frame][row][col] : TRANSPARENT_ENCODING;
    end
  end

endmodule

// File: rtl/sprite_anim_bitmap.sv
// Animated sprite bitmap: frame sequencer plus 2-stage pixel lookup.
// Latency 2 clk from offsets to RGBout; no backpressure, one pixel per clk.
// Ports: clk, reset (sync, active-high); startOfFrame/animEnable/playOnce/
//        restart drive the sequencer; mirrorX/offsetX/offsetY/InsideRectangle
//        address the pixel; outputs drawingRequest, RGBout, frameIndex, animDone.
// Build option: SPRITE_MIRROR_EN enables horizontal mirroring via mirrorX.
module sprite_anim_bitmap
  import sprite_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 26,
  parameter int OBJECT_HEIGHT_Y = 26,
  parameter int FRAME_COUNT     = 4,
  parameter int FRAME_PERIOD    = 8,
  localparam int FW = (FRAME_COUNT     > 1) ? $clog2(FRAME_COUNT)     : 1,
  localparam int RW = (OBJECT_HEIGHT_Y > 1) ? $clog2(OBJECT_HEIGHT_Y) : 1,
  localparam int CW = (OBJECT_WIDTH_X  > 1) ? $clog2(OBJECT_WIDTH_X)  : 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        animEnable,
  input  logic        playOnce,
  input  logic        restart,
  input  logic        mirrorX,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [3:0]  frameIndex,
  output logic        animDone
);

  localparam logic [7:0] PERIOD_LAST = 8'(FRAME_PERIOD - 1);
  localparam logic [3:0] FRAME_LAST  = 4'(FRAME_COUNT - 1);

  // ---------------- frame sequencer ----------------
  anim_state_t state_q, state_d;
  logic [3:0]  frame_q, frame_d;
  logic [7:0]  period_q, period_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      period_q <= period_d;
    end
  end

  // Frame only moves on an edge that samples startOfFrame or restart, so a
  // frame switch never lands in the middle of a raster line.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    period_d = period_q;
    if (restart) begin
      state_d  = playOnce ? ONESHOT : LOOP;
      frame_d  = '0;
      period_d = '0;
    end else if ((state_q == LOOP || state_q == ONESHOT) && startOfFrame && animEnable) begin
      if (period_q == PERIOD_LAST) begin
        period_d = '0;
        if (frame_q != FRAME_LAST) begin
          frame_d = frame_q + 4'd1;
        end else if (state_q == LOOP) begin
          frame_d = '0;
        end else begin
          // One-shot ran past the last frame: hold it and report done.
          state_d = DONE;
        end
      end else begin
        period_d = period_q + 8'd1;
      end
    end
  end

  assign frameIndex = frame_q;
  assign animDone   = (state_q == DONE);

  // ---------------- pixel path, stage 1 ----------------
  logic          pix_vld;
  logic [CW-1:0] col_sel;

  assign pix_vld = InsideRectangle &&
                   (offsetX < 11'(OBJECT_WIDTH_X)) &&
                   (offsetY < 11'(OBJECT_HEIGHT_Y));

  // Column arithmetic is done at ROM index width; it is exact whenever the
  // pixel is valid, and the result is discarded otherwise.
`ifdef SPRITE_MIRROR_EN
  assign col_sel = mirrorX ? (CW'(OBJECT_WIDTH_X - 1) - CW'(offsetX)) : CW'(offsetX);
`else
  logic unused_mirror;
  assign unused_mirror = mirrorX;
  assign col_sel       = CW'(offsetX);
`endif

  logic          pix_vld_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [FW-1:0] frm_q;

  // Invalid pixels park the address at 0 so the ROM is never indexed out of range.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_vld_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      frm_q     <= '0;
    end else begin
      pix_vld_q <= pix_vld;
      row_q     <= pix_vld ? RW'(offsetY) : '0;
      col_q     <= pix_vld ? col_sel : '0;
      frm_q     <= FW'(frame_q);
    end
  end

  // ---------------- pixel path, stage 2 ----------------
  sprite_frame_rom #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y),
    .FRAME_COUNT    (FRAME_COUNT)
  ) u_rom (
    .clk    (clk),
    .reset  (reset),
    .pix_vld(pix_vld_q),
    .frame  (frm_q),
    .row    (row_q),
    .col    (col_q),
    .rgb    (RGBout)
  );

  assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);

endmodule

// File: tb/tb_sprite_anim_bitmap.sv
// Bench for sprite_anim_bitmap: table vectors, directed sequencer sequences
// and randomized traffic, all checked every cycle against a reference model.
module tb_sprite_anim_bitmap;

  localparam int W  = 26;
  localparam int H  = 26;
  localparam int FC = 4;
  localparam int FP = 2;
`ifdef SPRITE_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, startOfFrame, animEnable, playOnce, restart, mirrorX;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic [3:0]  frameIndex;
  logic        animDone;

  always #5 clk = ~clk;

  sprite_anim_bitmap #(
    .OBJECT_WIDTH_X (W),
    .OBJECT_HEIGHT_Y(H),
    .FRAME_COUNT    (FC),
    .FRAME_PERIOD   (FP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .animEnable     (animEnable),
    .playOnce       (playOnce),
    .restart        (restart),
    .mirrorX        (mirrorX),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout),
    .frameIndex     (frameIndex),
    .animDone       (animDone)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Animation is described by the number of enabled pulses since the last
  // restart: steps = pulses / FP, loop shows steps mod FC, one-shot saturates.
  bit   m_active = 0;
  bit   m_once   = 0;
  int   m_pulses = 0;
  logic [7:0] p_s1  = 8'hFF;
  logic [7:0] p_out = 8'hFF;

  function automatic int m_steps();
    return m_pulses / FP;
  endfunction

  function automatic int m_frame();
    if (!m_active) return 0;
    if (m_once) return (m_steps() >= FC) ? FC - 1 : m_steps();
    return m_steps() % FC;
  endfunction

  function automatic bit m_done();
    return m_active && m_once && (m_steps() >= FC);
  endfunction

  function automatic logic [7:0] exp_pixel(input logic [3:0] fr, input logic [10:0] ox,
                                           input logic [10:0] oy, input logic ins,
                                           input logic mir);
    logic [10:0] col;
    if (!ins || ox >= W || oy >= H) return 8'hFF;
    col = (MIR && mir) ? (11'(W - 1) - ox) : ox;
    return {fr[1:0], oy[2:0], col[2:0]};
  endfunction

  // One clock: predict, advance model at the edge, compare #1 later.
  task automatic tick();
    logic [7:0] pe;
    pe = exp_pixel(4'(m_frame()), offsetX, offsetY, InsideRectangle, mirrorX);
    @(posedge clk);
    if (reset) begin
      m_active = 0;
      m_pulses = 0;
      p_s1     = 8'hFF;
      p_out    = 8'hFF;
    end else begin
      p_out = p_s1;
      p_s1  = pe;
      if (restart) begin
        m_active = 1;
        m_once   = playOnce;
        m_pulses = 0;
      end else if (m_active && startOfFrame && animEnable && !m_done()) begin
        m_pulses++;
      end
    end
    #1;
    check("rgb", RGBout, p_out);
    check("drawreq", {7'd0, drawingRequest}, {7'd0, p_out != 8'hFF});
    check("frame", {4'd0, frameIndex}, 8'(m_frame()));
    check("done", {7'd0, animDone}, {7'd0, m_done()});
  endtask

  task automatic pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_restart(input logic once);
    playOnce = once;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [10:0] ox;
    logic [10:0] oy;
    logic        ins;
    logic        mir;
    logic [7:0]  rgb;
    logic        dr;
  } vec_t;

  vec_t vecs [8];
  int   loop_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Vectors at frame 0: pixel = row%8*8 + col%8.
    vecs[0] = '{ox: 11'd0,  oy: 11'd0,  ins: 1'b1, mir: 1'b0, rgb: 8'h00, dr: 1'b1};
    vecs[1] = '{ox: 11'd5,  oy: 11'd3,  ins: 1'b1, mir: 1'b0, rgb: 8'h1D, dr: 1'b1};
    vecs[2] = '{ox: 11'd25, oy: 11'd25, ins: 1'b1, mir: 1'b0, rgb: 8'h09, dr: 1'b1};
    vecs[3] = '{ox: 11'd26, oy: 11'd5,  ins: 1'b1, mir: 1'b0, rgb: 8'hFF, dr: 1'b0};
    vecs[4] = '{ox: 11'd3,  oy: 11'd26, ins: 1'b1, mir: 1'b0, rgb: 8'hFF, dr: 1'b0};
    vecs[5] = '{ox: 11'd4,  oy: 11'd4,  ins: 1'b0, mir: 1'b0, rgb: 8'hFF, dr: 1'b0};
    vecs[6] = '{ox: 11'd7,  oy: 11'd7,  ins: 1'b1, mir: 1'b0, rgb: 8'h3F, dr: 1'b1};
`ifdef SPRITE_MIRROR_EN
    vecs[7] = '{ox: 11'd0,  oy: 11'd3,  ins: 1'b1, mir: 1'b1, rgb: 8'h19, dr: 1'b1};
`else
    vecs[7] = '{ox: 11'd0,  oy: 11'd3,  ins: 1'b1, mir: 1'b1, rgb: 8'h18, dr: 1'b1};
`endif

    reset = 1'b1; startOfFrame = 1'b0; animEnable = 1'b1; playOnce = 1'b0;
    restart = 1'b0; mirrorX = 1'b0; offsetX = 11'd0; offsetY = 11'd0;
    InsideRectangle = 1'b1;

    // Reset state and 2-clk release latency.
    repeat (3) tick();
    check("reset_rgb", RGBout, 8'hFF);
    check("reset_frame", {4'd0, frameIndex}, 8'd0);
    reset = 1'b0;
    tick();
    check("rel1_rgb", RGBout, 8'hFF);
    check("rel1_dr", {7'd0, drawingRequest}, 8'd0);
    tick();
    check("rel2_rgb", RGBout, 8'h00);
    check("rel2_dr", {7'd0, drawingRequest}, 8'd1);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      offsetX = vecs[i].ox; offsetY = vecs[i].oy;
      InsideRectangle = vecs[i].ins; mirrorX = vecs[i].mir;
      repeat (3) tick();
      check($sformatf("vec%0d_rgb", i), RGBout, vecs[i].rgb);
      check($sformatf("vec%0d_dr", i), {7'd0, drawingRequest}, {7'd0, vecs[i].dr});
    end
    mirrorX = 1'b0; offsetX = 11'd2; offsetY = 11'd1; InsideRectangle = 1'b1;

    // Loop mode: frame sequence sampled before each pulse.
    do_restart(1'b0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("loop_seq%0d", i), {4'd0, frameIndex}, 8'(loop_exp[i]));
      pulse();
      check("loop_done", {7'd0, animDone}, 8'd0);
    end

    // One-shot: reaches last frame, done after 8th pulse, restart clears.
    do_restart(1'b1);
    for (int i = 0; i < 7; i++) pulse();
    check("once7_done", {7'd0, animDone}, 8'd0);
    check("once7_frame", {4'd0, frameIndex}, 8'd3);
    pulse();
    check("once8_done", {7'd0, animDone}, 8'd1);
    check("once8_frame", {4'd0, frameIndex}, 8'd3);
    offsetX = 11'd7; offsetY = 11'd7;
    pulse(); pulse();
    check("once_hold", {4'd0, frameIndex}, 8'd3);
    check("f3_transp_rgb", RGBout, 8'hFF);
    check("f3_transp_dr", {7'd0, drawingRequest}, 8'd0);
    do_restart(1'b1);
    check("rst_once_frame", {4'd0, frameIndex}, 8'd0);
    check("rst_once_done", {7'd0, animDone}, 8'd0);

    // animEnable=0 freezes the sequencer.
    do_restart(1'b0);
    animEnable = 1'b0;
    repeat (4) pulse();
    check("hold_frame", {4'd0, frameIndex}, 8'd0);
    animEnable = 1'b1;

    // restart and startOfFrame together while looping at frame 2, period 1.
    do_restart(1'b0);
    repeat (5) pulse();
    check("pre_frame2", {4'd0, frameIndex}, 8'd2);
    startOfFrame = 1'b1; restart = 1'b1;
    tick();
    startOfFrame = 1'b0; restart = 1'b0;
    tick();
    check("coinc_frame", {4'd0, frameIndex}, 8'd0);
    pulse();
    check("coinc_period", {4'd0, frameIndex}, 8'd0);
    pulse();
    check("coinc_step", {4'd0, frameIndex}, 8'd1);

    // Reset mid-operation flushes the pipeline.
    offsetX = 11'd5; offsetY = 11'd3;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("flush_rgb", RGBout, 8'hFF);
    reset = 1'b0;
    tick();
    check("flush_s1_rgb", RGBout, 8'hFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      startOfFrame    = ($urandom_range(0, 4) == 0);
      restart         = ($urandom_range(0, 59) == 0);
      reset           = ($urandom_range(0, 299) == 0);
      animEnable      = ($urandom_range(0, 7) != 0);
      playOnce        = 1'($urandom_range(0, 1));
      mirrorX         = 1'($urandom_range(0, 1));
      InsideRectangle = ($urandom_range(0, 3) != 0);
      offsetX         = 11'($urandom_range(0, 31));
      offsetY         = 11'($urandom_range(0, 31));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
